// File: rtl/bsg_halfpod_reset_sequencer_pkg.sv
// Shared types for the halfpod reset sequencer: FSM state encoding and the reset/disable bundle.
// rseq_decode gives the Moore output bundle for each state, with releases accumulating along the sequence.
package bsg_halfpod_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        HOLD,
        DIS_OFF,
        TOKEN,
        UPLINK,
        DOWNLINK,
        DOWNSTREAM,
        DONE
    } bsg_halfpod_rseq_state_e;

    typedef struct packed {
        logic link_disable;
        logic token_reset;
        logic uplink_reset;
        logic downlink_reset;
        logic downstream_reset;
        logic core_reset;
    } bsg_halfpod_rseq_ctrl_s;

    localparam bsg_halfpod_rseq_ctrl_s rseq_hold_ctrl_lp = '{
        link_disable:     1'b1,
        token_reset:      1'b0,
        uplink_reset:     1'b1,
        downlink_reset:   1'b1,
        downstream_reset: 1'b1,
        core_reset:       1'b1
    };

    function automatic bsg_halfpod_rseq_ctrl_s rseq_decode(input bsg_halfpod_rseq_state_e s);
        bsg_halfpod_rseq_ctrl_s c;
        c = rseq_hold_ctrl_lp;
        case (s)
            DIS_OFF: begin
                c.link_disable = 1'b0;
            end
            TOKEN: begin
                c.link_disable = 1'b0;
                c.token_reset  = 1'b1;
            end
            UPLINK: begin
                c.link_disable = 1'b0;
                c.uplink_reset = 1'b0;
            end
            DOWNLINK: begin
                c.link_disable   = 1'b0;
                c.uplink_reset   = 1'b0;
                c.downlink_reset = 1'b0;
            end
            DOWNSTREAM: begin
                c.link_disable     = 1'b0;
                c.uplink_reset     = 1'b0;
                c.downlink_reset   = 1'b0;
                c.downstream_reset = 1'b0;
            end
            DONE: begin
                c.link_disable     = 1'b0;
                c.uplink_reset     = 1'b0;
                c.downlink_reset   = 1'b0;
                c.downstream_reset = 1'b0;
                c.core_reset       = 1'b0;
            end
            default: c = rseq_hold_ctrl_lp;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bsg_halfpod_rseq_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Latency: zero_o reflects the registered count; no backpressure.
module bsg_halfpod_rseq_timer #(
    parameter int width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    output logic               zero_o
);

    logic [width_p-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_halfpod_reset_sequencer.sv
// Ordered reset/disable release for a halfpod's SDR links and core, launched by a start_i rising edge.
// Latency: outputs registered, first change visible from the launch edge; launches while busy are dropped.
// Optional BSG_HALFPOD_RESET_SEQ_COUNT_EN adds seq_count_o, a wrapping count of completed sequences.
module bsg_halfpod_reset_sequencer
    import bsg_halfpod_reset_sequencer_pkg::*;
#(
    parameter int hold_cycles_p        = 16,
    parameter int token_pulse_cycles_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    output logic       link_disable_o,
    output logic       token_reset_o,
    output logic       uplink_reset_o,
    output logic       downlink_reset_o,
    output logic       downstream_reset_o,
    output logic       core_reset_o,
    output logic       busy_o,
    output logic       done_o
`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
    ,
    output logic [7:0] seq_count_o
`endif
);

    localparam int max_cycles_lp = (hold_cycles_p > token_pulse_cycles_p) ?
                                   hold_cycles_p : token_pulse_cycles_p;
    localparam int cnt_width_lp  = $clog2(max_cycles_lp + 1);

    bsg_halfpod_rseq_state_e state_q, state_d;
    bsg_halfpod_rseq_ctrl_s  ctrl_q, ctrl_d;
    logic                    start_q, start_d;
    logic                    relaunch_q, relaunch_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    launch;
    logic                    cnt_zero;
    logic                    cnt_load;
    logic [cnt_width_lp-1:0] cnt_load_val;

    always_comb begin
        start_d    = start_i;
        launch     = start_i & ~start_q;
        state_d    = state_q;
        relaunch_d = relaunch_q;

        case (state_q)
            HOLD: begin
                if (relaunch_q || launch) begin
                    state_d    = DIS_OFF;
                    relaunch_d = 1'b0;
                end
            end
            DIS_OFF:    if (cnt_zero) state_d = TOKEN;
            TOKEN:      if (cnt_zero) state_d = UPLINK;
            UPLINK:     if (cnt_zero) state_d = DOWNLINK;
            DOWNLINK:   if (cnt_zero) state_d = DOWNSTREAM;
            DOWNSTREAM: if (cnt_zero) state_d = DONE;
            DONE: begin
                // Re-run passes through one cycle of HOLD so every reset re-asserts.
                if (launch) begin
                    state_d    = HOLD;
                    relaunch_d = 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase

        cnt_load = (state_d != state_q);
        case (state_d)
            TOKEN:      cnt_load_val = cnt_width_lp'(token_pulse_cycles_p - 1);
            HOLD, DONE: cnt_load_val = '0;
            default:    cnt_load_val = cnt_width_lp'(hold_cycles_p - 1);
        endcase

        ctrl_d = rseq_decode(state_d);
        busy_d = (state_d != HOLD) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= HOLD;
            start_q    <= 1'b0;
            relaunch_q <= 1'b0;
            ctrl_q     <= rseq_hold_ctrl_lp;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            relaunch_q <= relaunch_d;
            ctrl_q     <= ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    bsg_halfpod_rseq_timer #(
        .width_p (cnt_width_lp)
    ) timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
    logic [7:0] seq_count_q, seq_count_d;

    always_comb begin
        seq_count_d = seq_count_q;
        if (state_q == DOWNSTREAM && state_d == DONE) begin
            seq_count_d = seq_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            seq_count_q <= '0;
        end else begin
            seq_count_q <= seq_count_d;
        end
    end

    assign seq_count_o = seq_count_q;
`endif

    assign link_disable_o     = ctrl_q.link_disable;
    assign token_reset_o      = ctrl_q.token_reset;
    assign uplink_reset_o     = ctrl_q.uplink_reset;
    assign downlink_reset_o   = ctrl_q.downlink_reset;
    assign downstream_reset_o = ctrl_q.downstream_reset;
    assign core_reset_o       = ctrl_q.core_reset;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_bsg_halfpod_reset_sequencer.sv
// Bench for the halfpod reset sequencer: default timing and a 1/1 instance driven from the same stimulus.
// An elapsed-time reference model feeds per-instance queues that a negedge monitor drains and compares.
module tb_bsg_halfpod_reset_sequencer;

    localparam int H0 = 16;
    localparam int P0 = 4;
    localparam int H1 = 1;
    localparam int P1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic done_stim = 1'b0;

    logic ld0, tk0, up0, dn0, ds0, cr0, bz0, dd0;
    logic ld1, tk1, up1, dn1, ds1, cr1, bz1, dd1;
    logic [7:0] sc0, sc1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    // Reference model state: phase 0=idle hold, 1=running (t = cycles since DIS_OFF entry), 2=done.
    int   m_phase[2];
    int   m_t[2];
    int   m_cnt[2];
    logic m_sr[2];
    logic m_rl[2];

    always #5 clk = ~clk;

    bsg_halfpod_reset_sequencer #(
        .hold_cycles_p        (H0),
        .token_pulse_cycles_p (P0)
    ) dut0 (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .start_i            (start),
        .link_disable_o     (ld0),
        .token_reset_o      (tk0),
        .uplink_reset_o     (up0),
        .downlink_reset_o   (dn0),
        .downstream_reset_o (ds0),
        .core_reset_o       (cr0),
        .busy_o             (bz0),
        .done_o             (dd0)
`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
        ,
        .seq_count_o        (sc0)
`endif
    );

    bsg_halfpod_reset_sequencer #(
        .hold_cycles_p        (H1),
        .token_pulse_cycles_p (P1)
    ) dut1 (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .start_i            (start),
        .link_disable_o     (ld1),
        .token_reset_o      (tk1),
        .uplink_reset_o     (up1),
        .downlink_reset_o   (dn1),
        .downstream_reset_o (ds1),
        .core_reset_o       (cr1),
        .busy_o             (bz1),
        .done_o             (dd1)
`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
        ,
        .seq_count_o        (sc1)
`endif
    );

`ifndef BSG_HALFPOD_RESET_SEQ_COUNT_EN
    assign sc0 = 8'd0;
    assign sc1 = 8'd0;
`endif

    task automatic model_step(input int i, input logic rn, input logic st, output logic [15:0] e);
        int   h;
        int   p;
        int   t;
        logic launch;
        h = (i == 0) ? H0 : H1;
        p = (i == 0) ? P0 : P1;
        if (!rn) begin
            m_phase[i] = 0;
            m_t[i]     = 0;
            m_sr[i]    = 1'b0;
            m_rl[i]    = 1'b0;
            m_cnt[i]   = 0;
        end else begin
            launch  = st && !m_sr[i];
            m_sr[i] = st;
            case (m_phase[i])
                0: if (m_rl[i] || launch) begin
                    m_phase[i] = 1;
                    m_t[i]     = 0;
                    m_rl[i]    = 1'b0;
                end
                1: begin
                    m_t[i] = m_t[i] + 1;
                    if (m_t[i] >= 4*h + p) begin
                        m_phase[i] = 2;
                        m_cnt[i]   = (m_cnt[i] + 1) % 256;
                    end
                end
                default: if (launch) begin
                    m_phase[i] = 0;
                    m_rl[i]    = 1'b1;
                end
            endcase
        end
        t = m_t[i];
        e[15:8] = 8'(m_cnt[i]);
`ifndef BSG_HALFPOD_RESET_SEQ_COUNT_EN
        e[15:8] = 8'd0;
`endif
        if (m_phase[i] == 0) begin
            e[7:0] = 8'b1_0_1_1_1_1_0_0;
        end else if (m_phase[i] == 2) begin
            e[7:0] = 8'b0_0_0_0_0_0_0_1;
        end else begin
            e[7] = 1'b0;
            e[6] = (t >= h) && (t < h + p);
            e[5] = (t < h + p);
            e[4] = (t < 2*h + p);
            e[3] = (t < 3*h + p);
            e[2] = 1'b1;
            e[1] = 1'b1;
            e[0] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        logic [15:0] e;
        model_step(0, rst_n, start, e);
        q0.push_back(e);
        model_step(1, rst_n, start, e);
        q1.push_back(e);
        cycle = cycle + 1;
    end

    always @(negedge clk) begin
        logic [15:0] exp_v;
        logic [7:0]  got;
        if (q0.size() > 0) begin
            exp_v = q0.pop_front();
            got = {ld0, tk0, up0, dn0, ds0, cr0, bz0, dd0};
            checks = checks + 1;
            if (got !== exp_v[7:0]) begin
                errors = errors + 1;
                $display("FAIL ctrl dut0 cycle %0d got %b want %b", cycle, got, exp_v[7:0]);
            end
`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
            checks = checks + 1;
            if (sc0 !== exp_v[15:8]) begin
                errors = errors + 1;
                $display("FAIL seq_count dut0 cycle %0d got %0d want %0d", cycle, sc0, exp_v[15:8]);
            end
`endif
        end
        if (q1.size() > 0) begin
            exp_v = q1.pop_front();
            got = {ld1, tk1, up1, dn1, ds1, cr1, bz1, dd1};
            checks = checks + 1;
            if (got !== exp_v[7:0]) begin
                errors = errors + 1;
                $display("FAIL ctrl dut1 cycle %0d got %b want %b", cycle, got, exp_v[7:0]);
            end
`ifdef BSG_HALFPOD_RESET_SEQ_COUNT_EN
            checks = checks + 1;
            if (sc1 !== exp_v[15:8]) begin
                errors = errors + 1;
                $display("FAIL seq_count dut1 cycle %0d got %0d want %0d", cycle, sc1, exp_v[15:8]);
            end
`endif
        end
    end

    task automatic step(input logic r, input logic s);
        rst_n = r;
        start = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic s;
        repeat (3)  step(1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b0);
        // Launch, then a second start edge while busy.
        repeat (20) step(1'b1, 1'b1);
        repeat (5)  step(1'b1, 1'b0);
        repeat (5)  step(1'b1, 1'b1);
        repeat (60) step(1'b1, 1'b0);
        // Re-run from DONE.
        repeat (10) step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b0);
        // Reset mid-sequence, then a fresh launch.
        repeat (5)  step(1'b1, 1'b1);
        repeat (25) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (5)  step(1'b1, 1'b0);
        repeat (3)  step(1'b1, 1'b1);
        repeat (75) step(1'b1, 1'b0);
        // Reset and launch on the same edge.
        step(1'b0, 1'b1);
        repeat (4)  step(1'b1, 1'b0);
        s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) s = ~s;
            step(($urandom_range(0, 249) != 0) ? 1'b1 : 1'b0, s);
        end
        repeat (5) step(1'b1, 1'b0);
        done_stim = 1'b1;
    end

    initial begin
        wait (done_stim);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
